// File: rtl/alu_issue_stage.sv
// RV32I issue stage: decodes the ALU op, selects operands and registers them behind a
// valid/ready output with a one-entry skid. Define ALU_ISSUE_FWD_EN to enable operand forwarding.
module alu_issue_stage #(
  parameter int XLEN = 32,
  parameter int OPW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imm_i,
`ifdef ALU_ISSUE_FWD_EN
  input  logic            fwd_valid_i,
  input  logic [4:0]      fwd_rd_i,
  input  logic [XLEN-1:0] fwd_data_i,
`endif
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  output logic [OPW-1:0]  alu_op_o,
  output logic [4:0]      rd_o,
  output logic            rd_we_o,
  output logic            illegal_o
);

  typedef enum logic [OPW-1:0] {
    OP_ADD = 'd0, OP_SUB = 'd1, OP_AND = 'd2, OP_OR  = 'd3, OP_XOR  = 'd4,
    OP_SLL = 'd5, OP_SRL = 'd6, OP_SRA = 'd7, OP_SLT = 'd8, OP_SLTU = 'd9
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [OPW-1:0]  op;
    logic [4:0]      rd;
    logic            rd_we;
    logic            illegal;
  } issue_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  function automatic alu_op_e f3_op(input logic [2:0] f3);
    unique case (f3)
      3'b000:  return OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];

`ifdef ALU_ISSUE_FWD_EN
  // A zero fwd_rd never matches: x0 is hard-wired and must not pick up forwarded data.
  assign rs1_val = (fwd_valid_i && fwd_rd_i != 5'd0 && fwd_rd_i == instr_i[19:15]) ? fwd_data_i : rs1_data_i;
  assign rs2_val = (fwd_valid_i && fwd_rd_i != 5'd0 && fwd_rd_i == instr_i[24:20]) ? fwd_data_i : rs2_data_i;
`else
  logic unused_rs_fields;
  assign unused_rs_fields = ^instr_i[24:15];
  assign rs1_val = rs1_data_i;
  assign rs2_val = rs2_data_i;
`endif

  issue_t dec;
  logic   writes;

  always_comb begin
    // NOTE: every field gets a default first so no path through the case leaves a latch.
    dec         = '0;
    dec.a       = rs1_val;
    dec.b       = imm_i;
    dec.op      = OP_ADD;
    dec.rd      = instr_i[11:7];
    writes      = 1'b1;
    unique case (opcode)
      OPC_R: begin
        dec.b = rs2_val;
        if (f7 == F7_BASE)                      dec.op = f3_op(f3);
        else if (f7 == F7_ALT && f3 == 3'b000) dec.op = OP_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101) dec.op = OP_SRA;
        else                                   dec.illegal = 1'b1;
      end
      OPC_I: begin
        if (f3 == 3'b001)      dec.illegal = (f7 != F7_BASE);
        if (f3 == 3'b101 && f7 == F7_ALT) dec.op = OP_SRA;
        else                   dec.op = f3_op(f3);
        if (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT) dec.illegal = 1'b1;
      end
      OPC_LUI:              dec.a = '0;
      OPC_AUIPC, OPC_JAL:   dec.a = pc_i;
      OPC_LOAD, OPC_JALR: ;
      OPC_STORE:            writes = 1'b0;
      OPC_BRANCH: begin
        writes = 1'b0;
        dec.b  = rs2_val;
        unique case (f3[2:1])
          2'b00:   dec.op = OP_SUB;
          2'b10:   dec.op = OP_SLT;
          2'b11:   dec.op = OP_SLTU;
          default: dec.illegal = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) dec.op = OP_ADD;
    dec.rd_we = writes && !dec.illegal && (dec.rd != 5'd0);
  end

  issue_t out_q, out_d, skid_q;
  logic   out_valid_q, out_valid_d;
  logic   skid_full_q, skid_full_d;
  logic   in_fire, out_fire;

  assign in_fire  = in_valid_i && !skid_full_q;
  assign out_fire = out_valid_q && out_ready_i;

  // Output reg refills from skid first, then from the input, so order is preserved.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    skid_full_d = skid_full_q;
    if (skid_full_q) begin
      if (out_fire) begin
        out_d       = skid_q;
        skid_full_d = 1'b0;
      end
    end else if (!out_valid_q || out_fire) begin
      out_valid_d = in_fire;
      if (in_fire) out_d = dec;
    end else if (in_fire) begin
      skid_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      skid_full_q <= skid_full_d;
    end
  end

  // NOTE: skid payload is not reset; skid_full_q alone says whether it holds anything.
  always_ff @(posedge clk) begin
    if (in_fire) skid_q <= dec;
  end

  assign in_ready_o  = !skid_full_q;
  assign out_valid_o = out_valid_q;
  assign alu_a_o     = out_q.a;
  assign alu_b_o     = out_q.b;
  assign alu_op_o    = out_q.op;
  assign rd_o        = out_q.rd;
  assign rd_we_o     = out_q.rd_we;
  assign illegal_o   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: decode vector table plus skid/backpressure,
// reset-discard and (with ALU_ISSUE_FWD_EN) forwarding sequences.
module tb_alu_issue_stage;
  localparam int XLEN = 32;
  localparam logic [31:0] RS1 = 32'hFFFF_FFFF;
  localparam logic [31:0] RS2 = 32'h0000_0001;
  localparam logic [31:0] IMM = 32'h3333_0003;
  localparam logic [31:0] PCV = 32'h4444_0004;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data, imm;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [4:0]  rd;
  logic        rd_we, illegal;
`ifdef ALU_ISSUE_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(XLEN), .OPW(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .pc_i(pc), .rs1_data_i(rs1_data), .rs2_data_i(rs2_data), .imm_i(imm),
`ifdef ALU_ISSUE_FWD_EN
    .fwd_valid_i(fwd_valid), .fwd_rd_i(fwd_rd), .fwd_data_i(fwd_data),
`endif
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
    .rd_o(rd), .rd_we_o(rd_we), .illegal_o(illegal)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        chk_ab;
    logic [31:0] a, b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        we, ill;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input string n, input logic [31:0] i, input logic c,
                             input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                             input logic [4:0] r, input logic we, input logic ill);
    vec_t t;
    t.name = n; t.instr = i; t.chk_ab = c; t.a = a; t.b = b;
    t.op = op; t.rd = r; t.we = we; t.ill = ill;
    return t;
  endfunction

  task automatic check_vec(input vec_t t);
    check({t.name, ".valid"}, 32'(out_valid), 32'd1);
    if (t.chk_ab) begin
      check({t.name, ".a"}, alu_a, t.a);
      check({t.name, ".b"}, alu_b, t.b);
    end
    check({t.name, ".op"},  32'(alu_op),  32'(t.op));
    check({t.name, ".rd"},  32'(rd),      32'(t.rd));
    check({t.name, ".we"},  32'(rd_we),   32'(t.we));
    check({t.name, ".ill"}, 32'(illegal), 32'(t.ill));
  endtask

  task automatic addi_item(input int k);
    instr = 32'h0000_0013 | (32'(k) << 7);
    imm   = 32'h100 + 32'(k);
  endtask

  initial begin
    vecs.push_back(v("sub",    32'h40B5_0533, 1, RS1, RS2, 4'd1, 5'd10, 1, 0));
    vecs.push_back(v("add",    32'h0031_00B3, 1, RS1, RS2, 4'd0, 5'd1,  1, 0));
    vecs.push_back(v("sra",    32'h4073_52B3, 1, RS1, RS2, 4'd7, 5'd5,  1, 0));
    vecs.push_back(v("sltu",   32'h0020_B0B3, 1, RS1, RS2, 4'd9, 5'd1,  1, 0));
    vecs.push_back(v("nop",    32'h0000_0013, 1, RS1, IMM, 4'd0, 5'd0,  0, 0));
    vecs.push_back(v("srai",   32'h4030_D093, 1, RS1, IMM, 4'd7, 5'd1,  1, 0));
    vecs.push_back(v("andi",   32'h0FF0_F093, 1, RS1, IMM, 4'd2, 5'd1,  1, 0));
    vecs.push_back(v("xori",   32'h0000_C093, 1, RS1, IMM, 4'd4, 5'd1,  1, 0));
    vecs.push_back(v("slli7",  32'h4000_9093, 0, 0,   0,   4'd0, 5'd1,  0, 1));
    vecs.push_back(v("lui",    32'h1234_51B7, 1, 0,   IMM, 4'd0, 5'd3,  1, 0));
    vecs.push_back(v("auipc",  32'h0000_1217, 1, PCV, IMM, 4'd0, 5'd4,  1, 0));
    vecs.push_back(v("jal",    32'h0000_00EF, 1, PCV, IMM, 4'd0, 5'd1,  1, 0));
    vecs.push_back(v("lw",     32'h0000_2103, 1, RS1, IMM, 4'd0, 5'd2,  1, 0));
    vecs.push_back(v("sw",     32'h0011_2223, 1, RS1, IMM, 4'd0, 5'd4,  0, 0));
    vecs.push_back(v("jalr0",  32'h0000_8067, 1, RS1, IMM, 4'd0, 5'd0,  0, 0));
    vecs.push_back(v("bne",    32'h0000_1063, 1, RS1, RS2, 4'd1, 5'd0,  0, 0));
    vecs.push_back(v("blt",    32'h0000_C063, 1, RS1, RS2, 4'd8, 5'd0,  0, 0));
    vecs.push_back(v("bltu",   32'h0000_E063, 1, RS1, RS2, 4'd9, 5'd0,  0, 0));
    // Branch f3=010 and f3=011 are not branches in RV32I.
    vecs.push_back(v("br010",  32'h0000_A063, 0, 0,   0,   4'd0, 5'd0,  0, 1));
    vecs.push_back(v("br011",  32'h0000_B063, 0, 0,   0,   4'd0, 5'd0,  0, 1));
    vecs.push_back(v("opc7f",  32'h0000_007F, 0, 0,   0,   4'd0, 5'd0,  0, 1));
    vecs.push_back(v("rf7_01", 32'h0200_80B3, 0, 0,   0,   4'd0, 5'd1,  0, 1));
    vecs.push_back(v("rf7alt", 32'h4000_90B3, 0, 0,   0,   4'd0, 5'd1,  0, 1));

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    instr = '0; pc = PCV; rs1_data = RS1; rs2_data = RS2; imm = IMM;
`ifdef ALU_ISSUE_FWD_EN
    fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.in_ready",  32'(in_ready),  32'd1);
    check("rst.alu_op",    32'(alu_op),    32'd0);
    check("rst.illegal",   32'(illegal),   32'd0);
    check("rst.alu_a",     alu_a,          32'd0);
    check("rst.rd_we",     32'(rd_we),     32'd0);

    // Streamed decode table with out_ready high: one result per cycle, no bubbles.
    instr = vecs[0].instr; in_valid = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      check_vec(vecs[i]);
      check({vecs[i].name, ".in_ready"}, 32'(in_ready), 32'd1);
      if (i + 1 < vecs.size()) instr = vecs[i + 1].instr;
      else in_valid = 1'b0;
    end
    @(negedge clk);
    check("drain.out_valid", 32'(out_valid), 32'd0);

    // Backpressure: three ADDIs against a stalled consumer.
    out_ready = 1'b0; in_valid = 1'b1; addi_item(1);
    @(negedge clk);
    check("bp.in_ready1", 32'(in_ready), 32'd1);
    addi_item(2);
    @(negedge clk);
    check("bp.in_ready2", 32'(in_ready), 32'd0);
    addi_item(3);
    repeat (3) @(negedge clk);
    check("bp.hold.b",     alu_b,          32'h101);
    check("bp.hold.rd",    32'(rd),        32'd1);
    check("bp.hold.valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.out2.b",      alu_b,         32'h102);
    check("bp.out2.rd",     32'(rd),       32'd2);
    check("bp.in_ready3",   32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp.out3.b",      alu_b,          32'h103);
    check("bp.out3.valid",  32'(out_valid), 32'd1);
    @(negedge clk);
    check("bp.empty",       32'(out_valid), 32'd0);
    imm = IMM;

    // Reset with both entries occupied discards them.
    out_ready = 1'b0; in_valid = 1'b1; addi_item(4);
    @(negedge clk);
    addi_item(5);
    @(negedge clk);
    in_valid = 1'b0;
    check("rmid.full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    check("rmid.out_valid", 32'(out_valid), 32'd0);
    check("rmid.in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    check("rmid.no_ghost",  32'(out_valid), 32'd0);

`ifdef ALU_ISSUE_FWD_EN
    rs1_data = 32'h1111; rs2_data = 32'h2222; imm = IMM;
    fwd_valid = 1'b1; fwd_rd = 5'd5; fwd_data = 32'hDEAD;
    instr = 32'h0052_80B3; in_valid = 1'b1;
    @(negedge clk);
    check("fwd.a", alu_a, 32'hDEAD);
    check("fwd.b", alu_b, 32'hDEAD);
    fwd_rd = 5'd0;
    @(negedge clk);
    in_valid = 1'b0;
    check("fwd0.a", alu_a, 32'h1111);
    check("fwd0.b", alu_b, 32'h2222);
    fwd_valid = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
